// File: rtl/pipe_pkg.sv
// Shared encodings and control bundle type for the MIPS control pipeline.
package pipe_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    // Jump is resolved in ID, so it is not part of the carried bundle.
    typedef struct packed {
        logic       regdst;
        logic       alusrc;
        logic       memtoreg;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic [1:0] aluop;
    } ctrl_t;

endpackage

// File: rtl/fwd_unit.sv
// EX operand source select: EX/MEM result beats MEM/WB result; r0 never forwards.
module fwd_unit
    import pipe_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic [RA_W-1:0] src,
    input  logic            mem_regwrite,
    input  logic [RA_W-1:0] mem_dst,
    input  logic            wb_regwrite,
    input  logic [RA_W-1:0] wb_dst,
    output logic [1:0]      fwd
);

    always_comb begin
        fwd = FWD_RF;
        if (mem_regwrite && (|mem_dst) && (mem_dst == src)) begin
            fwd = FWD_MEM;
        end else if (wb_regwrite && (|wb_dst) && (wb_dst == src)) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Control pipeline ID->EX->MEM->WB with load-use stall, branch/jump flush
// and EX operand forwarding select.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic            id_regdst,
    input  logic            id_alusrc,
    input  logic            id_memtoreg,
    input  logic            id_regwrite,
    input  logic            id_memread,
    input  logic            id_memwrite,
    input  logic            id_branch,
    input  logic            id_jump,
    input  logic [1:0]      id_aluop,
    input  logic [RA_W-1:0] id_rs,
    input  logic [RA_W-1:0] id_rt,
    input  logic [RA_W-1:0] id_rd,
    input  logic            ex_zero,
    output logic            stall,
    output logic            flush_ifid,
    output logic [1:0]      pc_sel,
    output logic            ex_regdst,
    output logic            ex_alusrc,
    output logic            ex_memtoreg,
    output logic            ex_regwrite,
    output logic            ex_memread,
    output logic            ex_memwrite,
    output logic            ex_branch,
    output logic [1:0]      ex_aluop,
    output logic [RA_W-1:0] ex_rs,
    output logic [RA_W-1:0] ex_rt,
    output logic [RA_W-1:0] ex_dst,
    output logic            mem_memtoreg,
    output logic            mem_regwrite,
    output logic            mem_memread,
    output logic            mem_memwrite,
    output logic [RA_W-1:0] mem_dst,
    output logic            wb_memtoreg,
    output logic            wb_regwrite,
    output logic [RA_W-1:0] wb_dst,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b
);

    ctrl_t           id_ctrl;
    ctrl_t           ctrl_p0;
    logic [RA_W-1:0] rs_p0, rt_p0, dst_p0;
    logic            memtoreg_p1, regwrite_p1, memread_p1, memwrite_p1;
    logic [RA_W-1:0] dst_p1;
    logic            memtoreg_p2, regwrite_p2;
    logic [RA_W-1:0] dst_p2;

    logic branch_taken, jump_taken, uses_rt, load_use, bubble;

    always_comb begin
        id_ctrl          = '0;
        id_ctrl.regdst   = id_regdst;
        id_ctrl.alusrc   = id_alusrc;
        id_ctrl.memtoreg = id_memtoreg;
        id_ctrl.regwrite = id_regwrite & ~id_jump;
        id_ctrl.memread  = id_memread;
        id_ctrl.memwrite = id_memwrite;
        id_ctrl.branch   = id_branch;
        id_ctrl.aluop    = id_aluop;
    end

    // Priority: taken branch in EX over load-use stall over jump in ID.
    assign branch_taken = ctrl_p0.branch & ex_zero;
    assign uses_rt      = ~(id_alusrc & ~id_memwrite);
    assign load_use     = id_valid & ctrl_p0.memread & (|dst_p0) &
                          ((dst_p0 == id_rs) | (uses_rt & (dst_p0 == id_rt)));
    assign stall        = load_use & ~branch_taken;
    assign jump_taken   = id_valid & id_jump & ~stall & ~branch_taken;
    assign flush_ifid   = branch_taken | jump_taken;
    assign bubble       = ~id_valid | stall | branch_taken;

    always_comb begin
        pc_sel = PC_PLUS4;
        if (branch_taken) begin
            pc_sel = PC_BRANCH;
        end else if (jump_taken) begin
            pc_sel = PC_JUMP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_p0     <= '0;
            rs_p0       <= '0;
            rt_p0       <= '0;
            dst_p0      <= '0;
            memtoreg_p1 <= 1'b0;
            regwrite_p1 <= 1'b0;
            memread_p1  <= 1'b0;
            memwrite_p1 <= 1'b0;
            dst_p1      <= '0;
            memtoreg_p2 <= 1'b0;
            regwrite_p2 <= 1'b0;
            dst_p2      <= '0;
        end else begin
            // ID -> EX
            if (bubble) begin
                ctrl_p0 <= '0;
                rs_p0   <= '0;
                rt_p0   <= '0;
                dst_p0  <= '0;
            end else begin
                ctrl_p0 <= id_ctrl;
                rs_p0   <= id_rs;
                rt_p0   <= id_rt;
                dst_p0  <= id_regdst ? id_rd : id_rt;
            end
            // EX -> MEM
            memtoreg_p1 <= ctrl_p0.memtoreg;
            regwrite_p1 <= ctrl_p0.regwrite;
            memread_p1  <= ctrl_p0.memread;
            memwrite_p1 <= ctrl_p0.memwrite;
            dst_p1      <= dst_p0;
            // MEM -> WB
            memtoreg_p2 <= memtoreg_p1;
            regwrite_p2 <= regwrite_p1;
            dst_p2      <= dst_p1;
        end
    end

    assign ex_regdst    = ctrl_p0.regdst;
    assign ex_alusrc    = ctrl_p0.alusrc;
    assign ex_memtoreg  = ctrl_p0.memtoreg;
    assign ex_regwrite  = ctrl_p0.regwrite;
    assign ex_memread   = ctrl_p0.memread;
    assign ex_memwrite  = ctrl_p0.memwrite;
    assign ex_branch    = ctrl_p0.branch;
    assign ex_aluop     = ctrl_p0.aluop;
    assign ex_rs        = rs_p0;
    assign ex_rt        = rt_p0;
    assign ex_dst       = dst_p0;
    assign mem_memtoreg = memtoreg_p1;
    assign mem_regwrite = regwrite_p1;
    assign mem_memread  = memread_p1;
    assign mem_memwrite = memwrite_p1;
    assign mem_dst      = dst_p1;
    assign wb_memtoreg  = memtoreg_p2;
    assign wb_regwrite  = regwrite_p2;
    assign wb_dst       = dst_p2;

    fwd_unit #(.RA_W(RA_W)) u_fwd_a (
        .src          (rs_p0),
        .mem_regwrite (regwrite_p1),
        .mem_dst      (dst_p1),
        .wb_regwrite  (regwrite_p2),
        .wb_dst       (dst_p2),
        .fwd          (fwd_a)
    );

    fwd_unit #(.RA_W(RA_W)) u_fwd_b (
        .src          (rt_p0),
        .mem_regwrite (regwrite_p1),
        .mem_dst      (dst_p1),
        .wb_regwrite  (regwrite_p2),
        .wb_dst       (dst_p2),
        .fwd          (fwd_b)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed hazard scenarios then a randomized instruction
// stream with a front end that honours stall/flush, checked against a stage model.
module tb_pipe_ctrl;
    import pipe_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_regdst, id_alusrc, id_memtoreg, id_regwrite;
    logic       id_memread, id_memwrite, id_branch, id_jump;
    logic [1:0] id_aluop;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       ex_zero;
    logic       stall, flush_ifid;
    logic [1:0] pc_sel;
    logic       ex_regdst, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite, ex_branch;
    logic [1:0] ex_aluop;
    logic [4:0] ex_rs, ex_rt, ex_dst;
    logic       mem_memtoreg, mem_regwrite, mem_memread, mem_memwrite;
    logic [4:0] mem_dst;
    logic       wb_memtoreg, wb_regwrite;
    logic [4:0] wb_dst;
    logic [1:0] fwd_a, fwd_b;

    pipe_ctrl #(.RA_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_regdst(id_regdst), .id_alusrc(id_alusrc), .id_memtoreg(id_memtoreg),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .id_branch(id_branch), .id_jump(id_jump), .id_aluop(id_aluop),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_zero(ex_zero),
        .stall(stall), .flush_ifid(flush_ifid), .pc_sel(pc_sel),
        .ex_regdst(ex_regdst), .ex_alusrc(ex_alusrc), .ex_memtoreg(ex_memtoreg),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_branch(ex_branch), .ex_aluop(ex_aluop), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_dst(ex_dst), .mem_memtoreg(mem_memtoreg), .mem_regwrite(mem_regwrite),
        .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .mem_dst(mem_dst),
        .wb_memtoreg(wb_memtoreg), .wb_regwrite(wb_regwrite), .wb_dst(wb_dst),
        .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       regdst, alusrc, memtoreg, regwrite, memread, memwrite, branch, jump;
        logic [1:0] aluop;
        logic [4:0] rs, rt, rd;
    } ins_t;

    // One instruction as seen in a pipeline stage (bubble = all zero).
    typedef struct packed {
        logic       regdst, alusrc, memtoreg, regwrite, memread, memwrite, branch;
        logic [1:0] aluop;
        logic [4:0] rs, rt, dst;
    } stg_t;

    stg_t m_ex, m_mem, m_wb;
    logic e_taken, e_stall, e_jump, e_flush;
    logic [1:0] e_pc, e_fa, e_fb;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic ins_t mk(input logic [5:0] op, input int s, input int t, input int d);
        ins_t r;
        r = '0;
        r.rs = s[4:0];
        r.rt = t[4:0];
        r.rd = d[4:0];
        case (op)
            OP_RTYPE: begin r.regdst = 1; r.regwrite = 1; r.aluop = 2'b10; end
            OP_LW:    begin r.alusrc = 1; r.memtoreg = 1; r.regwrite = 1; r.memread = 1; end
            OP_SW:    begin r.alusrc = 1; r.memwrite = 1; end
            OP_BEQ:   begin r.branch = 1; r.aluop = 2'b01; end
            OP_ANDI:  begin r.alusrc = 1; r.regwrite = 1; r.aluop = 2'b11; end
            OP_J:     r.jump = 1;
            default:  r = '0;
        endcase
        return r;
    endfunction

    function automatic ins_t rand_ins();
        logic [5:0] op;
        case ($urandom_range(0, 5))
            0: op = OP_RTYPE;
            1: op = OP_LW;
            2: op = OP_SW;
            3: op = OP_BEQ;
            4: op = OP_ANDI;
            default: op = OP_J;
        endcase
        return mk(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
    endfunction

    function automatic logic [1:0] fsel(input logic [4:0] src);
        if (m_mem.regwrite && m_mem.dst != 0 && m_mem.dst == src) return 2'b10;
        if (m_wb.regwrite && m_wb.dst != 0 && m_wb.dst == src) return 2'b01;
        return 2'b00;
    endfunction

    // Expected control decisions from the model state and the current ID inputs.
    task automatic calc();
        logic reads_rt, hz;
        e_taken  = m_ex.branch && ex_zero;
        reads_rt = !(id_alusrc && !id_memwrite);
        hz       = id_valid && m_ex.memread && m_ex.dst != 0 &&
                   (m_ex.dst == id_rs || (reads_rt && m_ex.dst == id_rt));
        e_stall  = hz && !e_taken;
        e_jump   = id_valid && id_jump && !e_stall && !e_taken;
        e_flush  = e_taken || e_jump;
        e_pc     = e_taken ? 2'b01 : (e_jump ? 2'b10 : 2'b00);
        e_fa     = fsel(m_ex.rs);
        e_fb     = fsel(m_ex.rt);
    endtask

    task automatic model_update();
        stg_t n;
        calc();
        n = '0;
        if (id_valid && !e_stall && !e_taken) begin
            n = {id_regdst, id_alusrc, id_memtoreg, id_regwrite && !id_jump, id_memread,
                 id_memwrite, id_branch, id_aluop, id_rs, id_rt, id_regdst ? id_rd : id_rt};
        end
        m_wb  = m_mem;
        m_mem = m_ex;
        m_ex  = n;
    endtask

    task automatic compare();
        calc();
        chk("stall", 32'(stall), 32'(e_stall));
        chk("flush_ifid", 32'(flush_ifid), 32'(e_flush));
        chk("pc_sel", 32'(pc_sel), 32'(e_pc));
        chk("fwd_a", 32'(fwd_a), 32'(e_fa));
        chk("fwd_b", 32'(fwd_b), 32'(e_fb));
        chk("ex_stage", 32'({ex_regdst, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread,
                             ex_memwrite, ex_branch, ex_aluop, ex_rs, ex_rt, ex_dst}), 32'(m_ex));
        chk("mem_stage", 32'({mem_memtoreg, mem_regwrite, mem_memread, mem_memwrite, mem_dst}),
            32'({m_mem.memtoreg, m_mem.regwrite, m_mem.memread, m_mem.memwrite, m_mem.dst}));
        chk("wb_stage", 32'({wb_memtoreg, wb_regwrite, wb_dst}),
            32'({m_wb.memtoreg, m_wb.regwrite, m_wb.dst}));
    endtask

    task automatic drive(input ins_t i, input bit v, input bit z);
        id_valid    = v;
        id_regdst   = i.regdst;
        id_alusrc   = i.alusrc;
        id_memtoreg = i.memtoreg;
        id_regwrite = i.regwrite;
        id_memread  = i.memread;
        id_memwrite = i.memwrite;
        id_branch   = i.branch;
        id_jump     = i.jump;
        id_aluop    = i.aluop;
        id_rs       = i.rs;
        id_rt       = i.rt;
        id_rd       = i.rd;
        ex_zero     = z;
    endtask

    // One clock: model follows the edge, new ID contents land, outputs are checked.
    task automatic step(input ins_t i, input bit v, input bit z);
        @(posedge clk);
        if (rst_n) model_update();
        @(negedge clk);
        drive(i, v, z);
        #1;
        compare();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ins_t nop, lw2, add3, cur;
        bit   cv;
        nop  = mk(OP_RTYPE, 0, 0, 0);
        lw2  = mk(OP_LW, 5, 2, 0);
        add3 = mk(OP_RTYPE, 2, 4, 3);
        m_ex = '0; m_mem = '0; m_wb = '0;
        rst_n = 1'b0;
        drive(nop, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_pc_sel", 32'(pc_sel), 32'd0);
        chk("rst_fwd", 32'({fwd_a, fwd_b}), 32'd0);
        chk("rst_wb", 32'({wb_regwrite, wb_dst}), 32'd0);
        compare();
        @(negedge clk);
        rst_n = 1'b1;

        // lw r2 ; add r3,r2,r4
        step(lw2, 1, 0);
        step(add3, 1, 0);
        chk("lu_stall", 32'(stall), 32'd1);
        step(add3, 1, 0);
        chk("lu_released", 32'(stall), 32'd0);
        chk("lu_bubble", 32'({ex_regwrite, ex_memread}), 32'd0);
        step(nop, 0, 0);
        chk("lu_fwd_a", 32'(fwd_a), 32'b01);
        chk("lu_fwd_b", 32'(fwd_b), 32'b00);
        chk("lu_wb", 32'({wb_memtoreg, wb_regwrite, wb_dst}), 32'({2'b11, 5'd2}));

        // add r1 ; sub r5,r1,r1 and add r1 ; add r1 ; and r6,r1,r1
        step(mk(OP_RTYPE, 2, 3, 1), 1, 0);
        step(mk(OP_RTYPE, 1, 1, 5), 1, 0);
        chk("alu_nostall", 32'(stall), 32'd0);
        step(nop, 0, 0);
        chk("alu_fwd", 32'({fwd_a, fwd_b}), 32'b1010);
        step(mk(OP_RTYPE, 2, 3, 1), 1, 0);
        step(mk(OP_RTYPE, 3, 2, 1), 1, 0);
        step(mk(OP_RTYPE, 1, 1, 6), 1, 0);
        step(nop, 0, 0);
        chk("prio_fwd", 32'({fwd_a, fwd_b}), 32'b1010);

        // beq taken, then not taken
        step(mk(OP_BEQ, 1, 1, 0), 1, 0);
        step(mk(OP_RTYPE, 2, 3, 7), 1, 1);
        chk("beq_pc", 32'({pc_sel, flush_ifid}), 32'b011);
        step(nop, 0, 0);
        chk("beq_killed_ex", 32'(ex_regwrite), 32'd0);
        step(nop, 0, 0);
        chk("beq_killed_mem", 32'(mem_regwrite), 32'd0);
        step(mk(OP_BEQ, 1, 2, 0), 1, 0);
        step(nop, 0, 0);
        chk("beq_nt", 32'({pc_sel, flush_ifid}), 32'b000);

        // jump alone, and jump while a branch is taken in EX
        step(mk(OP_J, 0, 0, 0), 1, 0);
        chk("j_pc", 32'({pc_sel, flush_ifid}), 32'b101);
        step(nop, 0, 0);
        step(mk(OP_BEQ, 3, 3, 0), 1, 0);
        step(mk(OP_J, 0, 0, 0), 1, 1);
        chk("j_vs_beq", 32'({pc_sel, flush_ifid}), 32'b011);
        step(nop, 0, 0);

        // r0 never hazards; andi and sw on a loaded register stall
        step(mk(OP_LW, 1, 0, 0), 1, 0);
        step(mk(OP_RTYPE, 0, 0, 3), 1, 0);
        chk("r0_nostall", 32'(stall), 32'd0);
        step(nop, 0, 0);
        chk("r0_fwd", 32'({fwd_a, fwd_b}), 32'd0);
        step(mk(OP_LW, 1, 2, 0), 1, 0);
        step(mk(OP_ANDI, 2, 7, 0), 1, 0);
        chk("andi_stall", 32'(stall), 32'd1);
        step(mk(OP_ANDI, 2, 7, 0), 1, 0);
        step(mk(OP_LW, 1, 2, 0), 1, 0);
        step(mk(OP_SW, 3, 2, 0), 1, 0);
        chk("sw_stall", 32'(stall), 32'd1);
        step(mk(OP_SW, 3, 2, 0), 1, 0);

        // asynchronous reset with a load in MEM
        step(lw2, 1, 0);
        step(nop, 0, 0);
        step(nop, 0, 0);
        chk("pre_rst_mem", 32'(mem_memread), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst", 32'({mem_memread, mem_regwrite, mem_memtoreg, wb_regwrite, ex_memread}), 32'd0);
        m_ex = '0; m_mem = '0; m_wb = '0;
        compare();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(nop, 0, 0);
        chk("post_rst_wb", 32'(wb_regwrite), 32'd0);

        // randomized stream; front end holds on stall and inserts bubble on flush
        cur = nop;
        cv  = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (e_flush) begin
                cv = 1'b0;
            end else if (!e_stall) begin
                cur = rand_ins();
                cv  = ($urandom_range(0, 9) != 0);
            end
            step(cur, cv, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Control-side pipeline for the 5-stage MIPS core. Accepts the decoded control bundle and register fields from the ID-stage main decoder and carries the control signals through ID/EX, EX/MEM and MEM/WB. Also performs load-use hazard detection, branch/jump flush generation and EX-stage operand forwarding select. The datapath consumes its outputs stage by stage.

## Interface
- `RA_W`, default 5: register address width.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset.
- `id_valid` in 1: the IF/ID register holds a real instruction.
- `id_regdst`, `id_alusrc`, `id_memtoreg`, `id_regwrite`, `id_memread`, `id_memwrite`, `id_branch`, `id_jump` in 1 each: decoder outputs for the ID instruction.
- `id_aluop` in 2: decoder ALU op class.
- `id_rs`, `id_rt`, `id_rd` in RA_W each: instruction register fields.
- `ex_zero` in 1: ALU zero flag for the EX instruction.
- `stall` out 1: hold PC and IF/ID (combinational).
- `flush_ifid` out 1: load a bubble into IF/ID next edge (combinational).
- `pc_sel` out 2: 00 = PC+4, 01 = branch target, 10 = jump target (combinational).
- `ex_regdst`, `ex_alusrc`, `ex_memtoreg`, `ex_regwrite`, `ex_memread`, `ex_memwrite`, `ex_branch` out 1 each; `ex_aluop` out 2; `ex_rs`, `ex_rt`, `ex_dst` out RA_W.
- `mem_memtoreg`, `mem_regwrite`, `mem_memread`, `mem_memwrite` out 1 each; `mem_dst` out RA_W.
- `wb_memtoreg`, `wb_regwrite` out 1 each; `wb_dst` out RA_W.
- `fwd_a`, `fwd_b` out 2: EX ALU operand A/B source. 00 = register file, 10 = EX/MEM, 01 = MEM/WB.

## Operation
**Reset.** Every registered output is 0, so all three stages hold bubbles. Combinational outputs settle to `stall`=0, `flush_ifid`=0, `pc_sel`=00, `fwd_*`=00.

**ID to EX.** Each edge loads the ID bundle into EX, with `ex_dst` = `id_regdst` ? `id_rd` : `id_rt`. A bubble (all control 0, fields 0) is loaded instead when any of these hold:
- `id_valid`=0;
- `stall`=1;
- `branch_taken`=1.

**EX to MEM to WB.** Unconditional shift every edge. `ex_branch`, `ex_alusrc`, `ex_aluop` and `ex_regdst` are not forwarded to MEM.

**Load-use hazard.**
- `uses_rt` = ~(`id_alusrc` & ~`id_memwrite`), i.e. R-type, beq and sw read rt.
- `stall` = `id_valid` & `ex_memread` & (`ex_dst`≠0) & ((`ex_dst`==`id_rs`) | (`uses_rt` & `ex_dst`==`id_rt`)) & ~`branch_taken`.

**Branch.** Resolved in EX.
- `branch_taken` = `ex_branch` & `ex_zero`.
- When taken: `pc_sel`=01, `flush_ifid`=1, and the ID instruction is bubbled into EX.

**Jump.** Resolved in ID.
- `jump_taken` = `id_valid` & `id_jump` & ~`stall` & ~`branch_taken`.
- When taken: `pc_sel`=10, `flush_ifid`=1. The jump itself proceeds into EX with no register write.
- Priority: branch_taken > stall > jump.

**Forwarding (operand A; operand B is the same with `ex_rt`).**
- `fwd_a`=10 if `mem_regwrite` & `mem_dst`≠0 & `mem_dst`==`ex_rs`.
- Otherwise `fwd_a`=01 if `wb_regwrite` & `wb_dst`≠0 & `wb_dst`==`ex_rs`.
- Otherwise `fwd_a`=00. EX/MEM wins when both stages match.

## Timing
- Control bundle latency: ID to EX 1 cycle, to MEM 2 cycles, to WB 3 cycles.
- `stall`, `flush_ifid`, `pc_sel` and `fwd_*` are purely combinational from current inputs and stage registers; there are no registered handshakes.
- A load-use stall lasts exactly one cycle: after one edge the load sits in MEM and `ex_memread` is 0. Any hazard that remains is resolved by forwarding from MEM/WB.
- Register 0 is never a hazard or forwarding source.
- Reset asserted mid-operation clears all stages immediately (asynchronous). The first edge after deassertion loads ID normally.
- Simultaneous branch_taken and load-use: no stall, branch flush only.

## Structure
- Shared package `pipe_pkg`:
  - opcode constants (R-type 000000, lw 100011, sw 101011, beq 000100, andi 001100, j 000010);
  - `pc_sel` encodings;
  - `fwd` encodings;
  - packed struct `ctrl_t` for the control bundle.
- One sub-module, `fwd_unit`: pure combinational forwarding-select logic, instantiated once per operand.
- All other logic stays in `pipe_ctrl`.

## Test plan
- **Reset then lw r2 followed by add r3,r2,r4:** `stall`=1 for exactly one cycle; a bubble enters EX; the next cycle `fwd_a`=01; `wb_dst`=2 with `wb_memtoreg`=1 three cycles after the lw leaves ID.
- **add r1 followed immediately by sub r5,r1,r1:** `fwd_a`=`fwd_b`=10 with no stall. add r1, add r1, and r1 gives `fwd`=10 (MEM priority over WB).
- **beq with `ex_zero`=1:** `pc_sel`=01, `flush_ifid`=1; the ID instruction never reaches MEM with `mem_regwrite` set. With `ex_zero`=0: `pc_sel`=00, no flush.
- **j with `id_valid`=1:** `pc_sel`=10 and `flush_ifid`=1 in the same cycle. When beq is taken in EX simultaneously, `pc_sel`=01.
- **lw r0 followed by add r3,r0,r0:** no stall, `fwd`=00. andi r7,r2 after lw r2: stall. sw after lw r2 with rt=r2: stall.
- **`rst_n` pulsed low while lw is in MEM:** all `mem_*` and `wb_*` outputs go to 0 asynchronously; no write reaches WB.
